// File: rtl/clkgate_pkg.sv
// Shared definitions for the activity-based clock gate controller.
//   state_e    : controller state encoding (RUN / GATED / WAKE)
//   WAKE_CNT_W : width of the wake settle counter
//   STATS_W    : width of the optional gate-event counter
package clkgate_pkg;

  localparam int unsigned WAKE_CNT_W = 4;
  localparam int unsigned STATS_W    = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

endpackage

// File: rtl/clkgate_ctrl.sv
// Activity-based controller producing the enable of a downstream latch-based
// clock gate. Drops en after idle_thresh consecutive idle cycles, restores it
// on any activity, and holds ready low for WAKE_DLY cycles after en returns.
// Runs on the free-running clock; one instance per gated domain.
//
// Ports:
//   clk          free-running clock
//   rstn         synchronous active-low reset
//   busy         gated domain has work in flight (level)
//   wake         external wake request (level)
//   force_on     software override, gating disabled while high
//   idle_thresh  idle cycles before gating, 0 disables gating (quasi-static)
//   en           clock gate enable, 1 = clock running
//   gated        1 while the domain clock is stopped
//   ready        domain clock running and settled
//   stats_clr    (CLKGATE_CTRL_STATS_EN) clear gate_events, wins over increment
//   gate_events  (CLKGATE_CTRL_STATS_EN) saturating count of RUN->GATED entries
//
// Optional feature macro: CLKGATE_CTRL_STATS_EN.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8,
  parameter int unsigned WAKE_DLY   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  busy,
  input  logic                  wake,
  input  logic                  force_on,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
`ifdef CLKGATE_CTRL_STATS_EN
  input  logic                  stats_clr,
  output logic [STATS_W-1:0]    gate_events,
`endif
  output logic                  en,
  output logic                  gated,
  output logic                  ready
);

  state_e                  state_q, state_d;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                    en_q, en_d;
  logic                    gated_q, gated_d;
  logic                    ready_q, ready_d;

  logic                    idle_c;
  logic                    thresh_on_c;
  logic [IDLE_CNT_W-1:0]   thresh_m1_c;

  assign idle_c      = ~busy & ~wake & ~force_on;
  assign thresh_on_c = (idle_thresh != '0);
  assign thresh_m1_c = idle_thresh - IDLE_CNT_W'(1);

  // Next state, counters, and outputs decoded from the next state so that
  // the output flops mirror the state flops with no input-to-output path.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (!idle_c || !thresh_on_c) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= thresh_m1_c) begin
          // >= so a lowered threshold gates on the next idle cycle
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        end
      end
      ST_GATED: begin
        idle_cnt_d = '0;
        if (!idle_c) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_CNT_W'(WAKE_DLY - 1);
        end
      end
      ST_WAKE: begin
        // Not abortable: always runs to RUN regardless of activity
        idle_cnt_d = '0;
        if (wake_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    en_d    = (state_d != ST_GATED);
    gated_d = (state_d == ST_GATED);
    ready_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b1;
      gated_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
      gated_q    <= gated_d;
      ready_q    <= ready_d;
    end
  end

  assign en    = en_q;
  assign gated = gated_q;
  assign ready = ready_q;

`ifdef CLKGATE_CTRL_STATS_EN
  logic [STATS_W-1:0] gate_ev_q, gate_ev_d;
  logic               gate_entry_c;

  assign gate_entry_c = (state_q == ST_RUN) && (state_d == ST_GATED);

  // Saturating event counter; clear beats increment
  always_comb begin
    gate_ev_d = gate_ev_q;
    if (stats_clr) begin
      gate_ev_d = '0;
    end else if (gate_entry_c && (gate_ev_q != '1)) begin
      gate_ev_d = gate_ev_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gate_ev_q <= '0;
    end else begin
      gate_ev_q <= gate_ev_d;
    end
  end

  assign gate_events = gate_ev_q;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Self-checking bench for clkgate_ctrl: directed scenarios with literal
// expectations plus randomized activity, all checked every cycle against an
// idle-run-length / settle-countdown model of the controller.
module tb_clkgate_ctrl;

  localparam int unsigned IDLE_CNT_W = 8;
  localparam int unsigned WAKE_DLY   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  busy;
  logic                  wake;
  logic                  force_on;
  logic [IDLE_CNT_W-1:0] idle_thresh;
  logic                  en;
  logic                  gated;
  logic                  ready;
`ifdef CLKGATE_CTRL_STATS_EN
  logic                  stats_clr;
  logic [15:0]           gate_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clkgate_ctrl #(
    .IDLE_CNT_W (IDLE_CNT_W),
    .WAKE_DLY   (WAKE_DLY)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .busy        (busy),
    .wake        (wake),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
`ifdef CLKGATE_CTRL_STATS_EN
    .stats_clr   (stats_clr),
    .gate_events (gate_events),
`endif
    .en          (en),
    .gated       (gated),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // Model: domain is either stopped, settling (countdown), or running while
  // accumulating the length of the current idle run.
  bit m_valid  = 1'b0;
  bit m_gated  = 1'b0;
  int m_settle = 0;
  int m_run    = 0;
  int m_events = 0;

  always @(posedge clk) begin
    bit idle_m;
    bit gate_now;
    idle_m   = !busy && !wake && !force_on;
    gate_now = 1'b0;
    if (!rstn) begin
      m_valid  = 1'b1;
      m_gated  = 1'b0;
      m_settle = 0;
      m_run    = 0;
      m_events = 0;
    end else begin
      if (m_gated) begin
        if (!idle_m) begin
          m_gated  = 1'b0;
          m_settle = WAKE_DLY;
        end
      end else if (m_settle > 0) begin
        m_settle = m_settle - 1;
        m_run    = 0;
      end else if (idle_m && idle_thresh != 0) begin
        m_run = m_run + 1;
        if (m_run >= int'(idle_thresh)) begin
          m_gated  = 1'b1;
          m_run    = 0;
          gate_now = 1'b1;
        end
      end else begin
        m_run = 0;
      end
`ifdef CLKGATE_CTRL_STATS_EN
      if (stats_clr) m_events = 0;
      else if (gate_now && m_events < 65535) m_events = m_events + 1;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_en",    32'(en),    32'(!m_gated));
      check("model_gated", 32'(gated), 32'(m_gated));
      check("model_ready", 32'(ready), 32'(!m_gated && m_settle == 0));
`ifdef CLKGATE_CTRL_STATS_EN
      check("model_gate_events", 32'(gate_events), 32'(m_events));
`endif
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn        = 1'b0;
    busy        = 1'b0;
    wake        = 1'b0;
    force_on    = 1'b0;
    idle_thresh = 8'd4;
`ifdef CLKGATE_CTRL_STATS_EN
    stats_clr   = 1'b0;
`endif
    step(2);
    rstn = 1'b1;
    busy = 1'b1;
    step(1);
    check("reset_en", 32'(en), 32'd1);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_gated", 32'(gated), 32'd0);

    // Four idle cycles with threshold 4 gate the clock on the fourth edge
    busy = 1'b0;
    step(3);
    check("pre_thresh_en", 32'(en), 32'd1);
    step(1);
    check("gate_en", 32'(en), 32'd0);
    check("gate_gated", 32'(gated), 32'd1);
    check("gate_ready", 32'(ready), 32'd0);

    // One-cycle wake: en back at the next edge, ready WAKE_DLY edges later
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    check("wake_en", 32'(en), 32'd1);
    check("wake_ready0", 32'(ready), 32'd0);
    step(1);
    check("wake_ready1", 32'(ready), 32'd0);
    step(1);
    check("wake_ready2", 32'(ready), 32'd1);

    // Activity on the threshold cycle keeps the clock running and restarts count
    step(3);
    busy = 1'b1;
    step(1);
    check("thresh_busy_en", 32'(en), 32'd1);
    busy = 1'b0;
    step(3);
    check("restart_en", 32'(en), 32'd1);
    step(1);
    check("restart_gate_en", 32'(en), 32'd0);

    // Reset while gated restores the clock on the next edge
    rstn = 1'b0;
    step(1);
    check("rst_gated_en", 32'(en), 32'd1);
    check("rst_gated_ready", 32'(ready), 32'd1);
    rstn = 1'b1;

    // Overrides: force_on, then threshold 0, over long idle stretches
    force_on = 1'b1;
    step(300);
    check("force_on_en", 32'(en), 32'd1);
    force_on    = 1'b0;
    idle_thresh = 8'd0;
    step(300);
    check("thresh0_en", 32'(en), 32'd1);

    // Lowering the threshold below the running count gates on the next idle cycle
    idle_thresh = 8'd10;
    step(6);
    idle_thresh = 8'd3;
    step(1);
    check("lowered_thresh_en", 32'(en), 32'd0);

    // Wake followed by immediate idle still completes the settle, then regates
    idle_thresh = 8'd2;
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    step(2);
    check("noabort_ready", 32'(ready), 32'd1);
    step(1);
    check("noabort_count_en", 32'(en), 32'd1);
    step(1);
    check("noabort_regate_en", 32'(en), 32'd0);

`ifdef CLKGATE_CTRL_STATS_EN
    stats_clr = 1'b1;
    busy = 1'b1;
    step(1);
    stats_clr = 1'b0;
    for (int g = 0; g < 3; g++) begin
      busy = 1'b1;
      step(4);
      busy = 1'b0;
      step(2);
    end
    check("stats_three", 32'(gate_events), 32'd3);
    busy = 1'b1;
    step(4);
    busy = 1'b0;
    step(1);
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    check("stats_clr_prio", 32'(gate_events), 32'd0);
    check("stats_clr_gated", 32'(gated), 32'd1);
`endif

    // Randomized activity, threshold changes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      busy     = ($urandom_range(0, 99) < 15);
      wake     = ($urandom_range(0, 99) < 5);
      force_on = ($urandom_range(0, 99) < 3);
      rstn     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) idle_thresh = 8'($urandom_range(0, 6));
`ifdef CLKGATE_CTRL_STATS_EN
      stats_clr = ($urandom_range(0, 99) < 2);
`endif
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
